// File: rtl/div_bus_ctrl.sv
// Bus front end for the sequential 16-bit divider: latches operands, issues init,
// waits for done (or a timeout) and exposes RESULT and status flags to firmware.
module div_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ZERO_RESULT    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        init,
  input  logic        done,
  input  logic [31:0] result,
  output logic [15:0] op_A,
  output logic [15:0] op_B
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e        state_q;
  logic [15:0]   opA_q;
  logic [15:0]   opB_q;
  logic [31:0]   result_q;
  logic [31:0]   dout_q;
  logic [CW-1:0] cnt_q;
  logic          init_q;
  logic          busy_q;
  logic          valid_q;
  logic          dz_q;
  logic          tmo_q;

  logic          wrEn;
  logic          rdEn;
  logic          startReq;
  logic [31:0]   rdData_d;
  logic          unusedBits;

  // A simultaneous read+write is treated as a write only, so d_out holds.
  assign wrEn       = cs & wr;
  assign rdEn       = cs & rd & ~wr;
  assign startReq   = wrEn && (addr == 3'd2) && d_in[0];
  assign unusedBits = ^d_in[31:16];

  always_comb begin
    rdData_d = '0;
    case (addr)
      3'd0:    rdData_d = {16'b0, opA_q};
      3'd1:    rdData_d = {16'b0, opB_q};
      3'd2:    rdData_d = {28'b0, tmo_q, dz_q, valid_q, busy_q};
      3'd3:    rdData_d = result_q;
      default: rdData_d = '0;
    endcase
  end

  // Operand registers freeze while an operation is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA_q  <= '0;
      opB_q  <= '0;
      dout_q <= '0;
    end else begin
      if (rdEn) begin
        dout_q <= rdData_d;
      end
      if (wrEn && !busy_q) begin
        if (addr == 3'd0) opA_q <= d_in[15:0];
        if (addr == 3'd1) opB_q <= d_in[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dz_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          init_q <= 1'b0;
          if (startReq) begin
            tmo_q <= 1'b0;
            if (opB_q == 16'd0) begin
              result_q <= ZERO_RESULT;
              dz_q     <= 1'b1;
              valid_q  <= 1'b1;
            end else begin
              valid_q <= 1'b0;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              init_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          init_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          init_q <= 1'b0;
          // done takes priority over a timeout landing on the same edge.
          if (done) begin
            result_q <= result;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (cnt_q == CntLast) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          init_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d_out = dout_q;
  assign init  = init_q;
  assign op_A  = opA_q;
  assign op_B  = opB_q;

endmodule

// File: doc/div_bus_ctrl.md
Name: div_bus_ctrl

Overview:
- Memory-mapped bus front end that initiates operations on the sequential 16-bit divider core.
- Latches operands written by the CPU and issues a one-cycle `init` pulse.
- Waits for the core's `done` pulse, captures `result`, and exposes busy/valid/error status for polling by firmware.
- Sits between the CPU peripheral bus and the divider; it is the initiator side of the divider's init/done handshake.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles from `init` to `done` before aborting; valid range 2..1023.
- ZERO_RESULT, 32'hFFFF_FFFF, value loaded into RESULT on divide-by-zero.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cs  in  1  peripheral select
- rd  in  1  read strobe, qualified by cs
- wr  in  1  write strobe, qualified by cs
- addr  in  3  word address: 0 OPA, 1 OPB, 2 CTRL/STATUS, 3 RESULT
- d_in  in  32  write data
- d_out  out  32  read data, registered
- init  out  1  start pulse to divider core
- done  in  1  completion pulse from divider core
- result  in  32  divider result, valid in the cycle done=1
- op_A  out  16  dividend to core
- op_B  out  16  divisor to core

Behaviour:
- Clock/reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: `d_out`=0, `init`=0, `op_A`=0, `op_B`=0. Internal state: RESULT=0, busy=0, valid=0, dz=0, tmo=0, counter=0, FSM=IDLE.
- Writes (cs&wr):
  - addr0 loads `op_A`<=d_in[15:0].
  - addr1 loads `op_B`<=d_in[15:0].
  - addr2 with d_in[0]=1 is a start request.
  - addr3 and d_in[31:16] are ignored.
  - Writes to addr0/1 while busy=1 are ignored; operands are stable for the whole operation.
- Reads (cs&rd): `d_out` updates on the next edge and holds until the next read.
  - addr0: {16'b0,op_A}; addr1: {16'b0,op_B}.
  - addr2: {28'b0,tmo,dz,valid,busy}.
  - addr3: RESULT.
  - Reads have no side effects.
- cs with both rd and wr: write takes effect, `d_out` unchanged.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: on a start request:
    - If op_B==0: RESULT<=ZERO_RESULT, dz<=1, valid<=1, tmo<=0. Stay in IDLE; no `init` is issued.
    - Otherwise: valid<=0, dz<=0, tmo<=0, busy<=1, go to ISSUE.
  - ISSUE: `init`=1 for exactly this one cycle (registered output, high for one clock). Counter<=0, go to WAIT.
  - WAIT: `init`=0; counter increments each cycle.
    - If done=1: RESULT<=result, valid<=1, busy<=0, go to IDLE.
    - Else if counter==TIMEOUT_CYCLES-1: tmo<=1, busy<=0, RESULT unchanged, go to IDLE.
- Latency: start-write edge -> `init` high 1 cycle later. Core done -> valid visible in STATUS read issued the following cycle.
- Handshake rules:
  - `done` is sampled only in WAIT; `done` seen in IDLE/ISSUE is ignored.
  - `done` and timeout in the same cycle: done wins (result captured, tmo=0).
  - Start request while busy=1 is ignored and leaves flags untouched.
  - `init` is never high for two consecutive cycles.
  - After a timeout, the next start is accepted normally.
- Reset mid-operation: FSM returns to IDLE immediately, `init` drops asynchronously, and all flags clear. A late `done` after reset is ignored.
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits; it never wraps.

Test Plan:
- Reset, then read addr2 and addr3 -> d_out=0 both; init=0, op_A=op_B=0.
- Write OPA=100, OPB=7, CTRL=1 -> init high exactly one cycle, 1 cycle after the CTRL write. STATUS reads busy=1. Model drives done with result=32'h0002_000E after 50 cycles -> STATUS=4'b0010, RESULT=32'h0002_000E.
- OPB=0, CTRL=1 -> no init pulse; STATUS=4'b0110, RESULT=32'hFFFF_FFFF.
- Start with model never asserting done, TIMEOUT_CYCLES=64 -> busy drops 64 cycles after init; STATUS=4'b1000, RESULT holds previous value. A following valid start succeeds with tmo cleared.
- While busy: write OPA=5 and CTRL=1 -> op_A unchanged, no second init, STATUS unchanged. Stray done pulse in IDLE -> valid unchanged.
- Assert reset 10 cycles into WAIT, then pulse done -> all outputs 0, STATUS=0, RESULT=0.
